// File: rtl/multibanco_ctrl.sv
// ATM transaction controller: card/PIN sequencing with lockout, withdrawal against a stored
// balance, and a sequential binary-to-BCD balance converter. Deposits enabled by MULTIBANCO_DEPOSIT_EN.
module multibanco_ctrl #(
  parameter int unsigned PIN_W      = 16,
  parameter int unsigned SALDO_W    = 12,
  parameter int unsigned BCD_DIG    = 4,
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned INIT_SALDO = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   card_in,
  input  logic [PIN_W-1:0]       pin,
  input  logic                   pin_vld,
  input  logic [PIN_W-1:0]       cod,
  input  logic [SALDO_W-1:0]     val,
  input  logic                   val_vld,
  input  logic                   op,
  output logic [2:0]             ecra,
  output logic [SALDO_W-1:0]     saldo,
  output logic [4*BCD_DIG-1:0]   saldo_bcd,
  output logic                   bcd_rdy,
  output logic                   disp,
  output logic                   lock
);

  localparam int unsigned BCD_W = 4 * BCD_DIG;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned CNT_W = $clog2(SALDO_W + 1);

  localparam logic [2:0] MSG_INSERT = 3'd0;
  localparam logic [2:0] MSG_PIN    = 3'd1;
  localparam logic [2:0] MSG_BADPIN = 3'd2;
  localparam logic [2:0] MSG_VALUE  = 3'd3;
  localparam logic [2:0] MSG_REJECT = 3'd4;
  localparam logic [2:0] MSG_WD_OK  = 3'd5;
  localparam logic [2:0] MSG_LOCKED = 3'd6;
  localparam logic [2:0] MSG_DEP_OK = 3'd7;

  typedef enum logic [2:0] {IDLE, PIN_WAIT, VAL_WAIT, CHECK, DONE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [2:0]         ecra_nxt;
  logic [SALDO_W-1:0] saldo_nxt, val_q, val_nxt;
  logic               disp_nxt, lock_nxt, saldo_upd;
  logic [TRY_W-1:0]   tries, tries_nxt;

`ifdef MULTIBANCO_DEPOSIT_EN
  logic               op_q, op_nxt;
  logic [SALDO_W:0]   sum_c;
  assign sum_c = {1'b0, saldo} + {1'b0, val_q};
`else
  logic               unused_op;
  assign unused_op = op;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ecra  <= MSG_INSERT;
      saldo <= SALDO_W'(INIT_SALDO);
      disp  <= 1'b0;
      lock  <= 1'b0;
      tries <= '0;
      val_q <= '0;
`ifdef MULTIBANCO_DEPOSIT_EN
      op_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ecra  <= ecra_nxt;
      saldo <= saldo_nxt;
      disp  <= disp_nxt;
      lock  <= lock_nxt;
      tries <= tries_nxt;
      val_q <= val_nxt;
`ifdef MULTIBANCO_DEPOSIT_EN
      op_q  <= op_nxt;
`endif
    end
  end

  // Next state and output values
  always_comb begin
    state_nxt = state;
    ecra_nxt  = ecra;
    saldo_nxt = saldo;
    disp_nxt  = 1'b0;
    lock_nxt  = lock;
    tries_nxt = tries;
    val_nxt   = val_q;
    saldo_upd = 1'b0;
`ifdef MULTIBANCO_DEPOSIT_EN
    op_nxt    = op_q;
`endif
    case (state)
      IDLE: begin
        if (card_in) begin
          state_nxt = PIN_WAIT;
          ecra_nxt  = MSG_PIN;
        end
      end
      PIN_WAIT: begin
        if (pin_vld) begin
          if (pin == cod) begin
            state_nxt = VAL_WAIT;
            ecra_nxt  = MSG_VALUE;
            tries_nxt = '0;
          end else begin
            tries_nxt = tries + TRY_W'(1);
            if (tries_nxt >= TRY_W'(MAX_TRIES)) begin
              state_nxt = LOCKED;
              ecra_nxt  = MSG_LOCKED;
              lock_nxt  = 1'b1;
            end else begin
              ecra_nxt  = MSG_BADPIN;
            end
          end
        end
      end
      VAL_WAIT: begin
        if (val_vld) begin
          val_nxt   = val;
`ifdef MULTIBANCO_DEPOSIT_EN
          op_nxt    = op;
`endif
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // Rejection is the fallback; accepted requests overwrite it below
        state_nxt = VAL_WAIT;
        ecra_nxt  = MSG_REJECT;
        if (val_q != '0) begin
`ifdef MULTIBANCO_DEPOSIT_EN
          if (op_q) begin
            if (!sum_c[SALDO_W]) begin
              saldo_nxt = sum_c[SALDO_W-1:0];
              saldo_upd = 1'b1;
              ecra_nxt  = MSG_DEP_OK;
              state_nxt = DONE;
            end
          end else
`endif
          if (val_q <= saldo) begin
            saldo_nxt = saldo - val_q;
            saldo_upd = 1'b1;
            disp_nxt  = 1'b1;
            ecra_nxt  = MSG_WD_OK;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
      end
      LOCKED: begin
        lock_nxt = 1'b1;
        ecra_nxt = MSG_LOCKED;
      end
      default: state_nxt = IDLE;
    endcase
    // Card removal aborts everything except lockout and an in-flight check
    if (!card_in && state != LOCKED && state != CHECK) begin
      state_nxt = IDLE;
      ecra_nxt  = MSG_INSERT;
      tries_nxt = tries;
      lock_nxt  = lock;
      val_nxt   = val_q;
    end
  end

  // Double-dabble converter: SALDO_W shift cycles, then publish
  logic [SALDO_W-1:0] bin_sh;
  logic [BCD_W-1:0]   acc, acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               run;

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < int'(BCD_DIG); d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sh    <= SALDO_W'(INIT_SALDO);
      acc       <= '0;
      cnt       <= CNT_W'(SALDO_W);
      run       <= 1'b1;
      saldo_bcd <= '0;
      bcd_rdy   <= 1'b0;
    end else if (saldo_upd) begin
      bin_sh  <= saldo_nxt;
      acc     <= '0;
      cnt     <= CNT_W'(SALDO_W);
      run     <= 1'b1;
      bcd_rdy <= 1'b0;
    end else if (run) begin
      if (cnt != '0) begin
        acc    <= {acc_adj[BCD_W-2:0], bin_sh[SALDO_W-1]};
        bin_sh <= bin_sh << 1;
        cnt    <= cnt - CNT_W'(1);
      end else begin
        saldo_bcd <= acc;
        bcd_rdy   <= 1'b1;
        run       <= 1'b0;
      end
    end
  end

endmodule
